// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES tone generators among note-on/note-off
// events. Each event walks IDLE -> LOOKUP -> COMMIT. The voice search is
// registered in LOOKUP so that COMMIT only has to apply a pre-decided update.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for an event; ev_ready high unless all_off
//   LOOKUP | captured event; match/free/oldest search is registered
//   COMMIT | voice table and ages updated from the registered search
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int MAX_NOTE   = 88
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [7:0]              ev_note,
    input  logic                    all_off,
    output logic [8*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    steal_pulse,
    output logic                    err_pulse,
    output logic                    busy
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       notes [NUM_VOICES];
    logic [AGE_W-1:0] ages  [NUM_VOICES];

    logic             on_q;
    logic [7:0]       note_q;

    logic             match_hit_c, free_hit_c;
    logic [IDX_W-1:0] match_idx_c, free_idx_c, old_idx_c;
    logic             match_hit_q, free_hit_q;
    logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_steal;

    logic accept;
    logic legal;

    assign ev_ready = (state == IDLE) && !all_off;
    assign busy     = (state != IDLE);
    assign accept   = ev_valid && ev_ready;
    assign legal    = (ev_note != 8'd0) && (ev_note <= 8'(MAX_NOTE));

    // Flatten the voice table onto the output bus and derive activity flags.
    always_comb begin
        voice_note   = '0;
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[8*i +: 8] = notes[i];
            voice_active[i]      = (notes[i] != 8'd0);
        end
    end

    // Voice search: lowest matching voice, lowest free voice, oldest voice
    // (ties resolved toward the lowest index by the strict compare).
    always_comb begin
        match_hit_c = 1'b0;
        match_idx_c = '0;
        free_hit_c  = 1'b0;
        free_idx_c  = '0;
        old_idx_c   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (notes[i] == note_q) begin
                match_hit_c = 1'b1;
                match_idx_c = IDX_W'(i);
            end
            if (notes[i] == 8'd0) begin
                free_hit_c = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (ages[i] > ages[old_idx_c]) begin
                old_idx_c = IDX_W'(i);
            end
        end
    end

    // Pick the voice a note-on lands on: retrigger, then free slot, then steal.
    always_comb begin
        commit_idx   = old_idx_q;
        commit_steal = 1'b0;
        if (match_hit_q) begin
            commit_idx = match_idx_q;
        end else if (free_hit_q) begin
            commit_idx = free_idx_q;
        end else begin
            commit_steal = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; all_off overrides everything and discards the event.
    always_comb begin
        state_nxt = state;
        if (all_off) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && legal) state_nxt = LOOKUP;
                LOOKUP:  state_nxt = COMMIT;
                COMMIT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Event capture, registered search results, voice table and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q        <= 1'b0;
            note_q      <= 8'd0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            steal_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= 8'd0;
                ages[i]  <= '0;
            end
        end else begin
            steal_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            if (all_off) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    notes[i] <= 8'd0;
                    ages[i]  <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            on_q   <= ev_on;
                            note_q <= ev_note;
                            if (!legal) begin
                                err_pulse <= 1'b1;
                            end
                        end
                    end
                    LOOKUP: begin
                        match_hit_q <= match_hit_c;
                        match_idx_q <= match_idx_c;
                        free_hit_q  <= free_hit_c;
                        free_idx_q  <= free_idx_c;
                        old_idx_q   <= old_idx_c;
                    end
                    COMMIT: begin
                        if (on_q) begin
                            steal_pulse <= commit_steal;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == commit_idx) begin
                                    notes[i] <= note_q;
                                    ages[i]  <= '0;
                                end else if (notes[i] != 8'd0 && ages[i] != AGE_MAX) begin
                                    ages[i] <= ages[i] + 1'b1;
                                end
                            end
                        end else if (match_hit_q) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == match_idx_q) begin
                                    notes[i] <= 8'd0;
                                    ages[i]  <= '0;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
